vdd_rail_sequencer: RTL and testbench

Power-up/power-down sequencer for the chip's VDD supply rails, one rail per top-level supply net (VDD1..VDD6). Enables rails one at a time in ascending index order and waits for each rail's power-good before settling and moving on. Powers down in descending order. Any power-good timeout or unexpected power-good loss drops every rail at once and latches a fault. Sits between the always-on control logic and the rail switch enables of the power distribution network.

---
 rtl/vdd_rail_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_vdd_rail_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vdd_rail_sequencer.sv
// Power sequencer for the VDD1..VDDn supply rails: ascending power-up with
// per-rail power-good and settle, descending power-down, and a global fault latch.
module vdd_rail_sequencer #(
  parameter int N_RAILS    = 6,
  parameter int PG_TIMEOUT = 1000,
  parameter int SETTLE_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       on_req,
  input  logic                       off_req,
  input  logic                       fault_clr,
  input  logic [N_RAILS-1:0]         pg,
  output logic [N_RAILS-1:0]         rail_en,
  output logic                       all_on,
  output logic                       all_off,
  output logic                       busy,
  output logic                       fault,
  output logic [$clog2(N_RAILS)-1:0] fault_rail
);

  localparam int IW   = $clog2(N_RAILS);
  localparam int MAXC = (PG_TIMEOUT > SETTLE_CYC) ? PG_TIMEOUT : SETTLE_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0] TO_LAST = TW'(PG_TIMEOUT - 1);
  localparam logic [TW-1:0] ST_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] TOP     = IW'(N_RAILS - 1);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    RAMP_UP   = 3'd1,
    SETTLE    = 3'd2,
    ON        = 3'd3,
    RAMP_DOWN = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [IW-1:0]      idx, idx_n, fault_rail_n, loss_rail;
  logic [TW-1:0]      timer, timer_n;
  logic [N_RAILS-1:0] rail_en_n;
  logic               on_req_q;
  logic               loss;

  // A rail counts as lost when it is enabled, already qualified, and its pg drops;
  // the rail still ramping in RAMP_UP is excluded. Lowest index wins.
  always_comb begin
    loss      = 1'b0;
    loss_rail = '0;
    for (int j = N_RAILS - 1; j >= 0; j--) begin
      if (rail_en[j] && !pg[j] &&
          ((j < int'(idx)) || ((j == int'(idx)) && (state != RAMP_UP)))) begin
        loss      = 1'b1;
        loss_rail = IW'(j);
      end
    end
    if (!(state inside {RAMP_UP, SETTLE, ON})) loss = 1'b0;
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    timer_n      = timer;
    rail_en_n    = rail_en;
    fault_rail_n = fault_rail;
    unique case (state)
      OFF: begin
        if (on_req_q) begin
          state_n      = RAMP_UP;
          idx_n        = '0;
          timer_n      = '0;
          rail_en_n    = '0;
          rail_en_n[0] = 1'b1;
        end
      end
      RAMP_UP: begin
        if (loss) begin
          state_n      = FAULT;
          fault_rail_n = loss_rail;
          rail_en_n    = '0;
        end else if (pg[idx]) begin
          state_n = SETTLE;
          timer_n = '0;
        end else if (timer == TO_LAST) begin
          state_n      = FAULT;
          fault_rail_n = idx;
          rail_en_n    = '0;
        end else if (off_req) begin
          state_n        = RAMP_DOWN;
          rail_en_n[idx] = 1'b0;
          timer_n        = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      SETTLE: begin
        if (loss) begin
          state_n      = FAULT;
          fault_rail_n = loss_rail;
          rail_en_n    = '0;
        end else if (off_req) begin
          state_n        = RAMP_DOWN;
          rail_en_n[idx] = 1'b0;
          timer_n        = '0;
        end else if (timer == ST_LAST) begin
          if (idx == TOP) begin
            state_n = ON;
          end else begin
            state_n          = RAMP_UP;
            idx_n            = idx + IW'(1);
            rail_en_n[idx_n] = 1'b1;
          end
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ON: begin
        if (loss) begin
          state_n      = FAULT;
          fault_rail_n = loss_rail;
          rail_en_n    = '0;
        end else if (off_req) begin
          state_n        = RAMP_DOWN;
          rail_en_n[idx] = 1'b0;
          timer_n        = '0;
        end
      end
      RAMP_DOWN: begin
        if (!pg[idx]) begin
          timer_n = '0;
          if (idx == '0) begin
            state_n = OFF;
          end else begin
            idx_n            = idx - IW'(1);
            rail_en_n[idx_n] = 1'b0;
          end
        end else if (timer == TO_LAST) begin
          state_n      = FAULT;
          fault_rail_n = idx;
          rail_en_n    = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      FAULT: begin
        rail_en_n = '0;
        if (fault_clr) begin
          state_n = OFF;
          idx_n   = '0;
          timer_n = '0;
        end
      end
      default: begin
        state_n   = OFF;
        rail_en_n = '0;
      end
    endcase
  end

  // on_req passes through one register stage before OFF acts on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OFF;
      idx        <= '0;
      timer      <= '0;
      rail_en    <= '0;
      fault_rail <= '0;
      on_req_q   <= 1'b0;
      all_on     <= 1'b0;
      all_off    <= 1'b1;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      timer      <= timer_n;
      rail_en    <= rail_en_n;
      fault_rail <= fault_rail_n;
      on_req_q   <= on_req;
      all_on     <= (state_n == ON);
      all_off    <= (state_n == OFF);
      busy       <= (state_n inside {RAMP_UP, SETTLE, RAMP_DOWN});
      fault      <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_vdd_rail_sequencer.sv
// Scoreboard bench for vdd_rail_sequencer: stimulus queues expected output
// snapshots with their cycle; a negedge monitor pops one per output change.
module tb_vdd_rail_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       on_req, off_req, fault_clr;
  logic [5:0] pg, rail_en;
  logic       all_on, all_off, busy, fault;
  logic [2:0] fault_rail;
  logic [5:0] force_low, force_high;

  typedef struct {
    logic [12:0] s;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic [2:0]  exp_fr;
  logic [12:0] prev;
  bit          seen = 1'b0;

  vdd_rail_sequencer #(.N_RAILS(6), .PG_TIMEOUT(8), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst(rst), .on_req(on_req), .off_req(off_req),
    .fault_clr(fault_clr), .pg(pg), .rail_en(rail_en), .all_on(all_on),
    .all_off(all_off), .busy(busy), .fault(fault), .fault_rail(fault_rail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Power-good follows each enable, with per-rail stuck-low / stuck-high overrides.
  assign pg = (rail_en & ~force_low) | force_high;

  function automatic logic [12:0] snap(input logic [5:0] en, input logic on_f,
                                       input logic off_f, input logic bsy,
                                       input logic flt, input logic [2:0] fr);
    return {en, on_f, off_f, bsy, flt, fr};
  endfunction

  task automatic push(input logic [12:0] s, input int c, input string name);
    exp_t e;
    e.s    = s;
    e.cyc  = c;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic check_output(input logic [12:0] cur);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL unexpected_change: got snap=%h at cycle %0d, required no change", cur, cyc);
    end else begin
      e = exp_q.pop_front();
      if (cur === e.s && cyc == e.cyc) passes++;
      else $display("[TB] FAIL %s: got snap=%h at cycle %0d, required snap=%h at cycle %0d",
                    e.name, cur, cyc, e.s, e.cyc);
    end
  endtask

  // Each visible change of any output is one scoreboard transaction.
  always @(negedge clk) begin
    if (!seen || {rail_en, all_on, all_off, busy, fault, fault_rail} !== prev) begin
      seen = 1'b1;
      prev = {rail_en, all_on, all_off, busy, fault, fault_rail};
      check_output(prev);
    end
  end

  // One-cycle on_req pulse; rail i enables 2+3i cycles later, all_on at +20.
  task automatic apply_power_up(input int n_en, input bit to_on, output int k);
    logic [5:0] en;
    k  = cyc;
    en = '0;
    on_req = 1'b1;
    for (int i = 0; i < n_en; i++) begin
      en[i] = 1'b1;
      push(snap(en, 1'b0, 1'b0, 1'b1, 1'b0, exp_fr), k + 2 + 3 * i, $sformatf("up_rail%0d", i));
    end
    if (to_on) push(snap(6'h3f, 1'b1, 1'b0, 1'b0, 1'b0, exp_fr), k + 20, "all_on");
    tick(1);
    on_req = 1'b0;
  endtask

  task automatic expect_ramp_down(input int top, input int start);
    logic [5:0] en;
    for (int i = top; i >= 0; i--) begin
      en = 6'((1 << i) - 1);
      push(snap(en, 1'b0, 1'b0, 1'b1, 1'b0, exp_fr), start + (top - i), $sformatf("down_rail%0d", i));
    end
    push(snap(6'h00, 1'b0, 1'b1, 1'b0, 1'b0, exp_fr), start + top + 1, "all_off");
  endtask

  task automatic apply_fault_clr();
    int f;
    f = cyc;
    fault_clr = 1'b1;
    push(snap(6'h00, 1'b0, 1'b1, 1'b0, 1'b0, exp_fr), f + 1, "fault_clr");
    tick(1);
    fault_clr = 1'b0;
  endtask

  initial begin
    int k, m;
    exp_t e;
    rst = 1'b1; on_req = 1'b0; off_req = 1'b0; fault_clr = 1'b0;
    force_low = '0; force_high = '0; exp_fr = 3'd0;
    push(snap(6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0), 1, "reset");
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("[TB] normal power-up and power-down");
    apply_power_up(6, 1'b1, k);
    wait_until(k + 22);
    m = cyc;
    off_req = 1'b1;
    expect_ramp_down(5, m + 1);
    tick(1);
    off_req = 1'b0;
    wait_until(m + 10);

    $display("[TB] ramp-up timeout on rail 2");
    force_low = 6'b000100;
    apply_power_up(3, 1'b0, k);
    exp_fr = 3'd2;
    push(snap(6'h00, 1'b0, 1'b0, 1'b0, 1'b1, exp_fr), k + 16, "up_timeout");
    wait_until(k + 18);
    apply_fault_clr();
    force_low = '0;
    tick(2);

    $display("[TB] pg loss on rails 1 and 4 while on");
    apply_power_up(6, 1'b1, k);
    wait_until(k + 22);
    m = cyc;
    force_low = 6'b010010;
    exp_fr = 3'd1;
    push(snap(6'h00, 1'b0, 1'b0, 1'b0, 1'b1, exp_fr), m + 1, "pg_loss");
    tick(2);
    apply_fault_clr();
    force_low = '0;
    tick(2);

    $display("[TB] abort from settle at rail 3");
    apply_power_up(4, 1'b0, k);
    wait_until(k + 12);
    off_req = 1'b1;
    expect_ramp_down(3, k + 13);
    tick(1);
    off_req = 1'b0;
    tick(1);
    on_req = 1'b1;
    tick(1);
    on_req = 1'b0;
    wait_until(k + 20);

    $display("[TB] ramp-down timeout with rail 5 stuck high");
    apply_power_up(6, 1'b1, k);
    wait_until(k + 22);
    force_high = 6'b100000;
    m = cyc;
    off_req = 1'b1;
    push(snap(6'h1f, 1'b0, 1'b0, 1'b1, 1'b0, exp_fr), m + 1, "down_start");
    exp_fr = 3'd5;
    push(snap(6'h00, 1'b0, 1'b0, 1'b0, 1'b1, exp_fr), m + 9, "down_timeout");
    tick(1);
    off_req = 1'b0;
    wait_until(m + 11);
    apply_fault_clr();
    force_high = '0;
    tick(2);

    $display("[TB] reset during ramp-up at rail 2");
    apply_power_up(3, 1'b0, k);
    wait_until(k + 8);
    rst = 1'b1;
    exp_fr = 3'd0;
    push(snap(6'h00, 1'b0, 1'b1, 1'b0, 1'b0, exp_fr), k + 9, "mid_reset");
    tick(1);
    rst = 1'b0;
    tick(4);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      $display("[TB] FAIL %s: got no change by cycle %0d, required snap=%h at cycle %0d",
               e.name, cyc, e.s, e.cyc);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
